// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point adder datapath.
package fp_pkg;

  localparam int unsigned MANT_W = 32;
  localparam int unsigned POS_W  = 5;
  localparam int unsigned EXP_W  = 8;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic              uflow;
  } norm_beat_t;

  typedef enum logic [1:0] {
    CLS_NORM  = 2'd0,
    CLS_ZERO  = 2'd1,
    CLS_UFLOW = 2'd2
  } norm_cls_t;

  // Zero input wins over underflow; a non-positive exponent difference underflows.
  function automatic norm_cls_t classify(input logic zero, input logic diff_neg,
                                         input logic diff_zero);
    if (zero)
      return CLS_ZERO;
    else if (diff_neg || diff_zero)
      return CLS_UFLOW;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/norm_pipe_reg.sv
// Valid/advance pipeline register with asynchronous active-low clear.
module norm_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid)
        out_data <= in_data;
    end
  end

endmodule

// File: rtl/normalize_shift32.sv
// Two-stage normalization shifter: coarse byte shift in S1, fine shift and
// classification in S2, valid/ready at full throughput.
module normalize_shift32 #(
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_mant,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [4:0]       in_pos,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero,
  output logic             out_uflow
);
  import fp_pkg::*;

  localparam int unsigned S1_W = MANT_W + 3 + 1 + EXP_W + 1;
  localparam int unsigned S2_W = MANT_W + EXP_W + 2;

  logic              s1_valid, s2_valid;
  logic              s1_adv, s2_adv;
  logic [S1_W-1:0]   s1_d, s1_q;
  logic [S2_W-1:0]   s2_d, s2_q;
  logic [MANT_W-1:0] coarse, s1_coarse, fine;
  logic [2:0]        s1_fine;
  logic              s1_zero;
  logic [EXP_W:0]    diff, s1_diff;
  norm_cls_t         cls;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    coarse = in_mant << {in_pos[4:3], 3'b000};
    diff   = {1'b0, in_exp} - (EXP_W+1)'(in_pos);
    s1_d   = {coarse, in_pos[2:0], in_zero, diff};
  end

  norm_pipe_reg #(.W(S1_W)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (s1_adv),
    .in_valid (in_valid),
    .in_data  (s1_d),
    .out_valid(s1_valid),
    .out_data (s1_q)
  );

  // The borrow bit of the widened difference flags a negative exponent.
  always_comb begin
    {s1_coarse, s1_fine, s1_zero, s1_diff} = s1_q;
    fine = s1_coarse << s1_fine;
    cls  = classify(s1_zero, s1_diff[EXP_W], s1_diff == '0);
    s2_d = '0;
    case (cls)
      CLS_NORM:  s2_d = {fine, s1_diff[EXP_W-1:0], 1'b0, 1'b0};
      CLS_ZERO:  s2_d = {{MANT_W{1'b0}}, {EXP_W{1'b0}}, 1'b1, 1'b0};
      CLS_UFLOW: s2_d = {{MANT_W{1'b0}}, {EXP_W{1'b0}}, 1'b1, 1'b1};
      default:   s2_d = {{MANT_W{1'b0}}, {EXP_W{1'b0}}, 1'b1, 1'b0};
    endcase
  end

  norm_pipe_reg #(.W(S2_W)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (s2_adv),
    .in_valid (s1_valid),
    .in_data  (s2_d),
    .out_valid(s2_valid),
    .out_data (s2_q)
  );

  assign out_valid = s2_valid;
  assign {out_mant, out_exp, out_zero, out_uflow} = s2_q;

endmodule
